// File: rtl/matrix_scanner_pkg.sv
// rtl/matrix_scanner_pkg.sv - shared types and constants for the LED matrix scanner
package matrix_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_e;

    localparam int BRIGHT_W  = 4;
    localparam int PWM_STEPS = 16;
    localparam int STEP_W    = $clog2(PWM_STEPS);

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_scanner_slot_timer.sv
// rtl/matrix_scanner_slot_timer.sv - blank/step/cycle counters for one column slot
module slot_timer
    import matrix_scanner_pkg::*;
#(
    parameter int STEP_CYCLES  = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  state_e            state_i,
    output logic              blank_done_o,
    output logic              slot_done_o,
    output logic [STEP_W-1:0] step_next_o
);

    localparam int CNT_MAX = (STEP_CYCLES > BLANK_CYCLES) ? STEP_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = idx_width(CNT_MAX);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [STEP_W-1:0] PWM_LAST   = STEP_W'(PWM_STEPS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              step_end;

    assign blank_done_o = (state_i == ST_BLANK) && (cnt_q == BLANK_LAST);
    assign step_end     = (state_i == ST_ON) && (cnt_q == STEP_LAST);
    assign slot_done_o  = step_end && (step_q == PWM_LAST);
    // The next step index lines up with the registered outputs in the top.
    assign step_next_o  = step_d;

    // Next-state counters: cycle counter inside BLANK or a PWM step, step index in ON.
    always_comb begin
        cnt_d  = cnt_q;
        step_d = step_q;
        if (clear_i || (state_i == ST_IDLE)) begin
            cnt_d  = '0;
            step_d = '0;
        end else if (state_i == ST_BLANK) begin
            if (blank_done_o) begin
                cnt_d  = '0;
                step_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_i == ST_ON) begin
            if (step_end) begin
                cnt_d  = '0;
                step_d = step_q + STEP_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q  <= '0;
            step_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

endmodule

// File: rtl/matrix_scanner.sv
// rtl/matrix_scanner.sv - column-multiplexed LED matrix driver with double-buffered image
module matrix_scanner
    import matrix_scanner_pkg::*;
#(
    parameter int ROWS           = 7,
    parameter int COLS           = 5,
    parameter int STEP_CYCLES    = 4,
    parameter int BLANK_CYCLES   = 2,
    parameter int ACTIVE_LOW_OUT = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [ROWS*COLS-1:0] image_i,
    input  logic                 image_load_i,
    input  logic [BRIGHT_W-1:0]  brightness_i,
    output logic [ROWS-1:0]      row_data_o,
    output logic [COLS-1:0]      col_drive_o,
    output logic                 frame_start_o,
    output logic                 load_pending_o
);

    localparam int               COL_W    = idx_width(COLS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic             INV      = (ACTIVE_LOW_OUT != 0);
    localparam logic [ROWS-1:0]  ROW_OFF  = {ROWS{INV}};
    localparam logic [COLS-1:0]  COL_OFF  = {COLS{INV}};

    state_e                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [BRIGHT_W-1:0]   bright_q, bright_d;
    logic [ROWS*COLS-1:0]  pend_q, pend_d;
    logic [ROWS*COLS-1:0]  disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic                  frame_start_q, frame_start_d;
    logic [ROWS-1:0]       row_data_q, row_data_d;
    logic [COLS-1:0]       col_drive_q, col_drive_d;

    logic                  blank_done;
    logic                  slot_done;
    logic [STEP_W-1:0]     step_next;
    logic                  enter_blank;
    logic                  boundary;
    logic                  lit;
    logic [ROWS-1:0]       row_sel;

    slot_timer #(
        .STEP_CYCLES  (STEP_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (!enable_i),
        .state_i      (state_q),
        .blank_done_o (blank_done),
        .slot_done_o  (slot_done),
        .step_next_o  (step_next)
    );

    // Scan FSM and column index; dropping enable abandons the frame at once.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE:  state_d = ST_BLANK;
            ST_BLANK: if (blank_done) state_d = ST_ON;
            ST_ON: begin
                if (slot_done) begin
                    state_d = ST_BLANK;
                    col_d   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        if (!enable_i || (state_q == ST_IDLE)) begin
            col_d = '0;
        end
        if (!enable_i) begin
            state_d = ST_IDLE;
        end
    end

    assign enter_blank   = enable_i && ((state_q == ST_IDLE) || ((state_q == ST_ON) && slot_done));
    assign boundary      = enter_blank && (col_d == '0);
    assign frame_start_d = boundary;
    assign bright_d      = enter_blank ? brightness_i : bright_q;

    // Image buffers: the commit happens during the frame_start cycle, which is
    // always a BLANK cycle of column 0, so the display never changes mid-frame.
    always_comb begin
        pend_d    = image_load_i ? image_i : pend_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (frame_start_q) begin
            pending_d = 1'b0;
            if (image_load_i) begin
                disp_d = image_i;
            end else if (pending_q) begin
                disp_d = pend_q;
            end
        end else if (image_load_i) begin
            pending_d = 1'b1;
        end
    end

    // Output pattern for the cycle after this edge, using next-state values so the
    // first ON cycle already drives the column.
    always_comb begin
        row_sel = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_d == COL_W'(c)) begin
                row_sel = disp_d[c*ROWS +: ROWS];
            end
        end
        lit         = (state_d == ST_ON) && (step_next <= bright_q);
        row_data_d  = (lit ? row_sel : '0) ^ ROW_OFF;
        col_drive_d = (lit ? (COLS'(1) << col_d) : '0) ^ COL_OFF;
    end

    // FSM state, column index and sampled brightness.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            bright_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            bright_q <= bright_d;
        end
    end

    // Pending and display buffers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pend_q    <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
        end
    end

    // Registered outputs, held inactive under reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            row_data_q    <= ROW_OFF;
            col_drive_q   <= COL_OFF;
            frame_start_q <= 1'b0;
        end else begin
            row_data_q    <= row_data_d;
            col_drive_q   <= col_drive_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_data_o     = row_data_q;
    assign col_drive_o    = col_drive_q;
    assign frame_start_o  = frame_start_q;
    assign load_pending_o = pending_q;

endmodule
